// File: rtl/slot_scan_arbiter_if.sv
// slot_scan_arbiter_if
// Purpose: bundles the write-port handshake and the multiplexed scan outputs
//          of slot_scan_arbiter into one interface.
// Signals:
//   wr_req      3         per-slot write request (requester i loads slot i)
//   wr_data     3*WIDTH   requester i data in [i*WIDTH +: WIDTH]
//   wr_gnt      3         one-hot (or zero) write grant
//   dwell       DWELL_W   slot display length minus one
//   blank_en    1         insert one blank cycle between slots
//   scan_data   WIDTH     active slot contents, 0 while blanking
//   scan_sel_n  3         active-low one-hot slot select, 111 while blanking
//   frame_pulse 1         one-cycle pulse at the start of each new frame
// Modports: master = user/driver side, slave = slot_scan_arbiter side.
interface slot_scan_arbiter_if #(
  parameter int WIDTH   = 3,
  parameter int DWELL_W = 4
);
  logic [2:0]         wr_req;
  logic [3*WIDTH-1:0] wr_data;
  logic [2:0]         wr_gnt;
  logic [DWELL_W-1:0] dwell;
  logic               blank_en;
  logic [WIDTH-1:0]   scan_data;
  logic [2:0]         scan_sel_n;
  logic               frame_pulse;

  modport master (
    output wr_req, wr_data, dwell, blank_en,
    input  wr_gnt, scan_data, scan_sel_n, frame_pulse
  );

  modport slave (
    input  wr_req, wr_data, dwell, blank_en,
    output wr_gnt, scan_data, scan_sel_n, frame_pulse
  );
endinterface

// File: rtl/slot_scan_arbiter.sv
// slot_scan_arbiter
// Purpose: three WIDTH-bit slot registers shown in turn on a shared scan bus.
//          A round-robin arbiter shares the single slot write port between
//          three requesters; a scan sequencer dwells dwell+1 cycles per slot
//          with an optional one-cycle blank gap between slots.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slot_scan_arbiter_if.slave (write handshake, dwell/blank control,
//          scan outputs and frame pulse)
module slot_scan_arbiter #(
  parameter int WIDTH   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  slot_scan_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_SCAN  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // Modulo-3 increment of a slot/pointer index.
  function automatic logic [1:0] next3(input logic [1:0] x);
    logic [1:0] r;
    case (x)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]   r_slot [3];
  logic [1:0]         r_ptr;
  logic [1:0]         r_idx;
  state_t             r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell_lat;
  logic               r_frame_pulse;

  logic [2:0]         w_gnt;
  logic [1:0]         w_gidx;
  logic [1:0]         w_k0;
  logic [1:0]         w_k1;
  logic [1:0]         w_k2;
  state_t             w_state_nxt;
  logic [1:0]         w_idx_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [DWELL_W-1:0] w_dwell_lat_nxt;
  logic [DWELL_W-1:0] w_lat;
  logic               w_frame_nxt;
  logic [2:0]         w_sel_n;
  logic [WIDTH-1:0]   w_data;

  // Round-robin grant search starting at the pointer; no grant during reset.
  always_comb begin
    w_gnt  = 3'b000;
    w_gidx = 2'd0;
    w_k0   = r_ptr;
    w_k1   = next3(r_ptr);
    w_k2   = next3(w_k1);
    if (rst) begin
      w_gnt = 3'b000;
    end else if (bus.wr_req[w_k0]) begin
      w_gidx = w_k0;
      w_gnt  = 3'b001 << w_k0;
    end else if (bus.wr_req[w_k1]) begin
      w_gidx = w_k1;
      w_gnt  = 3'b001 << w_k1;
    end else if (bus.wr_req[w_k2]) begin
      w_gidx = w_k2;
      w_gnt  = 3'b001 << w_k2;
    end else begin
      w_gnt = 3'b000;
    end
  end

  // Slot write port and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) r_slot[i] <= {WIDTH{1'b0}};
      r_ptr <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_gnt[i]) r_slot[i] <= bus.wr_data[i*WIDTH +: WIDTH];
      end
      if (w_gnt != 3'b000) r_ptr <= next3(w_gidx);
      else                 r_ptr <= r_ptr;
    end
  end

  // On the first cycle of a slot the live dwell input is the slot length;
  // afterwards the value latched on that cycle is used.
  assign w_lat = (r_cnt == {DWELL_W{1'b0}}) ? bus.dwell : r_dwell_lat;

  // Scan sequencer next-state logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_frame_nxt     = 1'b0;
    w_dwell_lat_nxt = r_dwell_lat;
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == {DWELL_W{1'b0}}) w_dwell_lat_nxt = bus.dwell;
        else                          w_dwell_lat_nxt = r_dwell_lat;
        if (r_cnt == w_lat) begin
          w_cnt_nxt = {DWELL_W{1'b0}};
          if (bus.blank_en) begin
            w_state_nxt = ST_BLANK;
          end else begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = next3(r_idx);
            // Leaving slot 2 means the next cycle starts a new frame.
            w_frame_nxt = (r_idx == 2'd2);
          end
        end else begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end
      end
      ST_BLANK: begin
        w_state_nxt = ST_SCAN;
        w_idx_nxt   = next3(r_idx);
        w_cnt_nxt   = {DWELL_W{1'b0}};
        w_frame_nxt = (r_idx == 2'd2);
      end
      default: begin
        w_state_nxt = ST_SCAN;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = {DWELL_W{1'b0}};
      end
    endcase
  end

  // Scan sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_SCAN;
      r_idx         <= 2'd0;
      r_cnt         <= {DWELL_W{1'b0}};
      r_dwell_lat   <= {DWELL_W{1'b0}};
      r_frame_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      r_dwell_lat   <= w_dwell_lat_nxt;
      r_frame_pulse <= w_frame_nxt;
    end
  end

  // Scan output decode from registered state.
  always_comb begin
    w_sel_n = 3'b111;
    w_data  = {WIDTH{1'b0}};
    if (r_state == ST_SCAN) begin
      case (r_idx)
        2'd0: begin w_sel_n = 3'b110; w_data = r_slot[0]; end
        2'd1: begin w_sel_n = 3'b101; w_data = r_slot[1]; end
        2'd2: begin w_sel_n = 3'b011; w_data = r_slot[2]; end
        default: begin w_sel_n = 3'b111; w_data = {WIDTH{1'b0}}; end
      endcase
    end else begin
      w_sel_n = 3'b111;
      w_data  = {WIDTH{1'b0}};
    end
  end

  assign bus.wr_gnt      = w_gnt;
  assign bus.scan_sel_n  = w_sel_n;
  assign bus.scan_data   = w_data;
  assign bus.frame_pulse = r_frame_pulse;

endmodule

// File: tb/tb_slot_scan_arbiter.sv
// tb_slot_scan_arbiter
// Purpose: directed, table-driven bench for slot_scan_arbiter. Each table row
//          holds inputs and expected outputs for one or more cycles; short
//          hand-written sequences cover mid-slot reset and arbitration
//          rotation from reset.
module tb_slot_scan_arbiter;
  localparam int WIDTH   = 3;
  localparam int DWELL_W = 4;

  logic clk;
  logic rst;

  slot_scan_arbiter_if #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) bus ();

  slot_scan_arbiter #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [8:0] data;
    logic [3:0] dwell;
    logic       blank;
    int         reps;
    logic [2:0] gnt;
    logic [2:0] sel;
    logic [2:0] sdata;
    logic       fp;     // expected on the first repetition only
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [2:0] req, input logic [8:0] data,
                     input logic [3:0] dwell, input logic blank, input int reps,
                     input logic [2:0] gnt, input logic [2:0] sel,
                     input logic [2:0] sdata, input logic fp);
    vec_t v;
    v.req = req; v.data = data; v.dwell = dwell; v.blank = blank; v.reps = reps;
    v.gnt = gnt; v.sel = sel; v.sdata = sdata; v.fp = fp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] gnt,
                            input logic [2:0] sel, input logic [2:0] sdata,
                            input logic fp);
    check({tag, ".gnt"}, {29'd0, bus.wr_gnt}, {29'd0, gnt});
    check({tag, ".sel_n"}, {29'd0, bus.scan_sel_n}, {29'd0, sel});
    check({tag, ".data"}, {29'd0, bus.scan_data}, {29'd0, sdata});
    check({tag, ".fp"}, {31'd0, bus.frame_pulse}, {31'd0, fp});
  endtask

  initial begin
    logic [2:0] arb_exp [4];

    // Idle, dwell 0, no blanking: one cycle per slot, pulse every 3 cycles.
    add(3'b000, 9'd0, 4'd0, 1'b0, 1, 3'b000, 3'b110, 3'd0, 1'b0); // c0
    add(3'b000, 9'd0, 4'd0, 1'b0, 1, 3'b000, 3'b101, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd0, 1'b0, 1, 3'b000, 3'b011, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd0, 1'b0, 1, 3'b000, 3'b110, 3'd0, 1'b1); // c3
    add(3'b000, 9'd0, 4'd0, 1'b0, 1, 3'b000, 3'b101, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd0, 1'b0, 1, 3'b000, 3'b011, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd0, 1'b0, 1, 3'b000, 3'b110, 3'd0, 1'b1); // c6
    // Sequential writes slot0=5, slot1=2, slot2=7.
    add(3'b001, {3'd0, 3'd0, 3'd5}, 4'd0, 1'b0, 1, 3'b001, 3'b101, 3'd0, 1'b0);
    add(3'b010, {3'd0, 3'd2, 3'd0}, 4'd0, 1'b0, 1, 3'b010, 3'b011, 3'd0, 1'b0);
    add(3'b100, {3'd7, 3'd0, 3'd0}, 4'd0, 1'b0, 1, 3'b100, 3'b110, 3'd5, 1'b1);
    // dwell = 3: four cycles per slot.
    add(3'b000, 9'd0, 4'd3, 1'b0, 4, 3'b000, 3'b101, 3'd2, 1'b0); // c10-13
    add(3'b000, 9'd0, 4'd3, 1'b0, 4, 3'b000, 3'b011, 3'd7, 1'b0); // c14-17
    add(3'b000, 9'd0, 4'd3, 1'b0, 4, 3'b000, 3'b110, 3'd5, 1'b1); // c18-21
    // dwell = 1 with blanking: 2 scan + 1 blank per slot, 9-cycle frame.
    add(3'b000, 9'd0, 4'd1, 1'b1, 2, 3'b000, 3'b101, 3'd2, 1'b0); // c22-23
    add(3'b000, 9'd0, 4'd1, 1'b1, 1, 3'b000, 3'b111, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd1, 1'b1, 2, 3'b000, 3'b011, 3'd7, 1'b0);
    add(3'b000, 9'd0, 4'd1, 1'b1, 1, 3'b000, 3'b111, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd1, 1'b1, 2, 3'b000, 3'b110, 3'd5, 1'b1); // c28
    add(3'b000, 9'd0, 4'd1, 1'b1, 1, 3'b000, 3'b111, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd1, 1'b1, 2, 3'b000, 3'b101, 3'd2, 1'b0);
    add(3'b000, 9'd0, 4'd1, 1'b1, 1, 3'b000, 3'b111, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd1, 1'b1, 2, 3'b000, 3'b011, 3'd7, 1'b0);
    add(3'b000, 9'd0, 4'd1, 1'b1, 1, 3'b000, 3'b111, 3'd0, 1'b0);
    add(3'b000, 9'd0, 4'd1, 1'b1, 1, 3'b000, 3'b110, 3'd5, 1'b1); // c37
    // Blanking off at the last cycle; dwell 7 mid-slot must not stretch it.
    add(3'b000, 9'd0, 4'd7, 1'b0, 1, 3'b000, 3'b110, 3'd5, 1'b0); // c38
    // Slot 1 at dwell 7, rewritten to 4 while displayed.
    add(3'b000, 9'd0, 4'd7, 1'b0, 2, 3'b000, 3'b101, 3'd2, 1'b0); // c39-40
    add(3'b010, {3'd0, 3'd4, 3'd0}, 4'd7, 1'b0, 1, 3'b010, 3'b101, 3'd2, 1'b0);
    add(3'b000, 9'd0, 4'd7, 1'b0, 5, 3'b000, 3'b101, 3'd4, 1'b0); // c42-46
    add(3'b000, 9'd0, 4'd7, 1'b0, 1, 3'b000, 3'b011, 3'd7, 1'b0); // c47

    rst = 1'b1;
    bus.wr_req = 3'b000; bus.wr_data = 9'd0; bus.dwell = 4'd0; bus.blank_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 3'b000, 3'b110, 3'd0, 1'b0);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int v = 0; v < vecs.size(); v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        bus.wr_req   = vecs[v].req;
        bus.wr_data  = vecs[v].data;
        bus.dwell    = vecs[v].dwell;
        bus.blank_en = vecs[v].blank;
        @(negedge clk);
        check_outs($sformatf("vec%0d.%0d", v, r), vecs[v].gnt, vecs[v].sel,
                   vecs[v].sdata, (r == 0) ? vecs[v].fp : 1'b0);
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of slot 2 with requests pending.
    bus.wr_req = 3'b111; bus.wr_data = {3'd6, 3'd6, 3'd6}; bus.dwell = 4'd7;
    #2;
    rst = 1'b1;
    #1;
    check_outs("midrst", 3'b000, 3'b110, 3'd0, 1'b0);
    @(posedge clk); #1;
    bus.wr_req = 3'b000; bus.dwell = 4'd0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      case (k)
        0: check_outs("post_rst0", 3'b000, 3'b110, 3'd0, 1'b0);
        1: check_outs("post_rst1", 3'b000, 3'b101, 3'd0, 1'b0);
        2: check_outs("post_rst2", 3'b000, 3'b011, 3'd0, 1'b0);
        default: check_outs("post_rst3", 3'b000, 3'b110, 3'd0, 1'b1);
      endcase
      @(posedge clk); #1;
    end

    // All three requesting from reset: rotation 001, 010, 100.
    rst = 1'b1;
    bus.wr_req = 3'b111; bus.wr_data = {3'd3, 3'd2, 3'd1};
    @(negedge clk);
    check("arb_in_reset.gnt", {29'd0, bus.wr_gnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    arb_exp[0] = 3'b001; arb_exp[1] = 3'b010; arb_exp[2] = 3'b100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("arb111_%0d.gnt", k), {29'd0, bus.wr_gnt}, {29'd0, arb_exp[k]});
      @(posedge clk); #1;
    end
    bus.wr_req = 3'b101;
    arb_exp[0] = 3'b001; arb_exp[1] = 3'b100; arb_exp[2] = 3'b001; arb_exp[3] = 3'b100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("arb101_%0d.gnt", k), {29'd0, bus.wr_gnt}, {29'd0, arb_exp[k]});
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
